// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size and FSM encodings plus lane widths for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE, LOAD, MERGE, WR} state_e;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: little-endian lane select with sign/zero extension for loads
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              signed_ld,
  output logic [WORD_W-1:0] value
);
  logic [BYTE_W-1:0] b;
  logic [HALF_W-1:0] h;
  always_comb begin
    b = word[{offset, 3'b000} +: BYTE_W];
    h = offset[1] ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
    value = size == SZ_BYTE ? {{(WORD_W-BYTE_W){signed_ld & b[BYTE_W-1]}}, b}
          : size == SZ_HALF ? {{(WORD_W-HALF_W){signed_ld & h[HALF_W-1]}}, h}
          : word;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-access LSU with one-cycle loads and read-modify-write sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_MEM_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d, sgn_q, sgn_d, done_q, done_d, err_q, err_d;
  logic        bad;
  logic [31:0] ld_val, merged;

  lsu_load_align u_align (
    .word     (mem_read_data),
    .offset   (addr_q[1:0]),
    .size     (size_q),
    .signed_ld(sgn_q),
    .value    (ld_val)
  );

  always_comb begin
    bad = size == SZ_RSVD || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00)
          || addr[31:2] >= 30'(DATA_MEM_SIZE);
    merged = mem_read_data;
    if (size_q == SZ_BYTE) merged[{addr_q[1:0], 3'b000} +: BYTE_W] = wdata_q[BYTE_W-1:0];
    else merged[{addr_q[1], 4'b0000} +: HALF_W] = wdata_q[HALF_W-1:0];
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    we_d    = we_q;
    sgn_d   = sgn_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        addr_d  = addr;
        wdata_d = wdata;
        size_d  = size;
        we_d    = we;
        sgn_d   = signed_ld;
        done_d  = bad;
        err_d   = bad;
        state_d = bad ? IDLE : !we ? LOAD : size == SZ_WORD ? WR : MERGE;
      end
      LOAD: begin
        rdata_d = ld_val;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      MERGE: begin
        wdata_d = merged;
        state_d = WR;
      end
      WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy           = state_q != IDLE;
  assign mem_addr       = busy ? {addr_q[31:2], 2'b00} : '0;
  assign mem_write      = state_q == WR && we_q;
  assign mem_write_data = wdata_q;
  assign done           = done_q;
  assign err            = err_q;
  assign rdata          = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed accesses checked every cycle against a transaction-level model
module tb_load_store_unit;
  logic        clk = 0, rst = 1, req = 0, we = 0, signed_ld = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        busy, done, err, mem_write;
  logic [31:0] rdata, mem_addr, mem_write_data, mem_read_data;
  logic [31:0] tb_mem [64];
  logic [31:0] ref_mem [64];
  logic        exp_busy = 0, exp_done = 0, exp_err = 0, exp_mw = 0, chk_en = 0;
  logic [31:0] exp_maddr = 0, exp_rdata = 0, exp_mwd = 0;
  int          n_tests = 0, n_fail = 0;

  load_store_unit #(.DATA_MEM_SIZE(64)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .signed_ld(signed_ld),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = tb_mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr[7:2]] <= mem_write_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    mask = sz == 0 ? 32'hFF : 32'hFFFF;
    sh = sz == 0 ? 8 * a[1:0] : 16 * a[1];
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  function automatic logic m_bad(input logic [31:0] a, input logic [1:0] sz);
    return sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0) || (a >> 2) >= 64;
  endfunction

  always @(negedge clk) if (chk_en) begin
    check("busy", {31'b0, busy}, {31'b0, exp_busy});
    check("done", {31'b0, done}, {31'b0, exp_done});
    check("err", {31'b0, err}, {31'b0, exp_err});
    check("mem_write", {31'b0, mem_write}, {31'b0, exp_mw});
    check("mem_addr", mem_addr, exp_maddr);
    check("rdata", rdata, exp_rdata);
    if (exp_mw) check("mem_write_data", mem_write_data, exp_mwd);
  end

  task automatic idle();
    req = 0;
    exp_busy = 0; exp_mw = 0; exp_maddr = 0;
    @(posedge clk); #1;
    exp_done = 0; exp_err = 0;
  endtask

  // Issues one access from an IDLE cycle and returns at the start of its completion cycle.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic hold);
    int idx;
    logic bad;
    bad = m_bad(a, sz);
    idx = int'(a[7:2]);
    req = 1; we = w; size = sz; signed_ld = sg; addr = a; wdata = wd;
    exp_busy = 0; exp_mw = 0; exp_maddr = 0;
    @(posedge clk); #1;
    exp_done = 0; exp_err = 0;
    if (bad) begin
      req = 0; exp_done = 1; exp_err = 1;
      return;
    end
    req = hold;
    if (hold) begin
      we = 1'($urandom); size = 2'($urandom); addr = $urandom_range(0, 255); wdata = $urandom;
    end
    exp_busy = 1; exp_maddr = a & 32'hFFFFFFFC;
    if (!w) begin
      @(posedge clk); #1;
      exp_rdata = m_load(ref_mem[idx], a, sz, sg);
    end else if (sz == 2) begin
      exp_mw = 1; exp_mwd = wd;
      @(posedge clk); #1;
      ref_mem[idx] = wd;
    end else begin
      @(posedge clk); #1;
      exp_mw = 1; exp_mwd = m_merge(ref_mem[idx], a, sz, wd);
      @(posedge clk); #1;
      ref_mem[idx] = exp_mwd;
    end
    req = 0; exp_busy = 0; exp_mw = 0; exp_maddr = 0; exp_done = 1;
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    int off, idx;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[0] = 32'h8899AABB; ref_mem[0] = 32'h8899AABB;
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    @(negedge clk); @(negedge clk); #1;
    rst = 0;
    chk_en = 1;
    do_op(0, 2'd0, 1, 32'h1, 32'h0, 0);
    check("load_byte_signed", rdata, 32'hFFFFFFAA);
    check("load_byte_done", {30'b0, done, err}, 32'd2);
    do_op(0, 2'd1, 0, 32'h2, 32'h0, 0);
    check("load_half_unsigned", rdata, 32'h00008899);
    do_op(1, 2'd0, 0, 32'h3, 32'h5C, 0);
    check("store_byte_word0", tb_mem[0], 32'h5C99AABB);
    check("store_byte_done", {31'b0, done}, 32'd1);
    do_op(1, 2'd2, 0, 32'h10, 32'h12345678, 1);
    check("store_word_word4", tb_mem[4], 32'h12345678);
    do_op(0, 2'd2, 0, 32'h6, 32'h0, 0);
    check("misaligned_err", {30'b0, done, err}, 32'd3);
    do_op(0, 2'd2, 0, 32'h100, 32'h0, 0);
    check("range_err", {30'b0, done, err}, 32'd3);
    check("err_rdata_kept", rdata, 32'h00008899);
    for (int i = 0; i < 400; i++) begin
      sz = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      idx = $urandom_range(0, 15) == 0 ? $urandom_range(64, 300) : $urandom_range(0, 63);
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) off = sz == 1 ? off & 2 : sz == 2 ? 0 : off;
      a = (32'(idx) << 2) | 32'(off);
      do_op(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle(); idle();
    req = 1; we = 1; size = 2'd1; signed_ld = 0; addr = 32'h8; wdata = 32'hBEEF;
    @(posedge clk); #1;
    req = 0;
    chk_en = 0;
    #2 rst = 1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_outputs", {29'b0, done, err, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    check("rst_no_write", {31'b0, mem_write}, 32'd0);
    check("rst_mem_kept", tb_mem[2], ref_mem[2]);
    @(negedge clk); #1;
    rst = 0;
    exp_busy = 0; exp_done = 0; exp_err = 0; exp_mw = 0; exp_maddr = 0; exp_rdata = 0;
    chk_en = 1;
    do_op(0, 2'd2, 0, 32'h8, 32'h0, 0);
    check("post_rst_load", rdata, ref_mem[2]);
    do_op(1, 2'd1, 1, 32'hA, 32'h1234, 0);
    idle(); idle();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_MEM_SIZE, default 64, number of 32-bit words in the attached data memory.
REQ-002 SHALL have ports as below; one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  1  access request from the pipeline MEM stage.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- signed_ld  input  1  sign-extend sub-word loads.
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned for sub-word stores.
- busy  output  1  access in progress; high in every non-IDLE state.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle error pulse, coincident with done.
- rdata  output  32  load result, registered.
- mem_addr  output  32  word-aligned address to data memory.
- mem_write  output  1  data memory write enable.
- mem_write_data  output  32  data memory write data.
- mem_read_data  input  32  combinational read data from data memory.

Function
REQ-003 SHALL sample req only in IDLE; req while busy=1 is ignored, with no queuing.
REQ-004 SHALL use FSM states IDLE, LOAD, MERGE, WR.
- Accept at edge E0 latches addr, wdata, size, we and signed_ld.
- Transitions from IDLE: load -> LOAD; word store -> WR; byte or halfword store -> MERGE.
- Transitions onward: LOAD -> IDLE; MERGE -> WR; WR -> IDLE.
REQ-005 SHALL drive mem_addr = {latched addr[31:2], 2'b00} in LOAD, MERGE and WR, and 0 in IDLE.
REQ-006 SHALL assert mem_write combinationally from state, only in WR, for exactly one cycle per store.
REQ-007 Load: SHALL register the extracted value into rdata and pulse done at E1.
- Latency is 1 cycle.
REQ-008 Load extraction SHALL be little-endian.
- Byte: lane addr[1:0], where lane k = bits [8k+7:8k].
- Halfword: addr[1] selects [31:16] when 1, [15:0] when 0.
- Word: the whole word.
- Sub-word results zero-extend when signed_ld=0 and sign-extend when signed_ld=1.
REQ-009 Word store: mem_write_data = latched wdata during WR (E0-E1); done pulses at E1.
REQ-010 Sub-word store (read-modify-write):
- MERGE (E0-E1): read mem_read_data and register the word with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
- WR (E1-E2): write the merged word; done pulses at E2.
REQ-011 SHALL treat the following as errors:
- size=11;
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- addr[31:2] >= DATA_MEM_SIZE.
REQ-012 On error SHALL stay in IDLE, issue no memory access, leave rdata unchanged, and pulse done=1 and err=1 at E1.
REQ-013 done and err SHALL be registered and be zero in every cycle other than the completion cycle.
REQ-014 rdata SHALL hold its value until the next successful load completes; stores do not change it.
REQ-015 SHALL accept a new req in the cycle done is high, since the FSM is then in IDLE.
- Loads sustain one completion every 2 cycles.

Reset
REQ-016 rst=1 SHALL immediately force the following, independent of clk:
- state IDLE;
- busy=0, done=0, err=0, mem_write=0, mem_addr=0;
- rdata=0 and all latched fields 0.
REQ-017 Reset asserted during LOAD or MERGE SHALL abort the access.
- No write is issued.
- No done pulse follows reset release.
REQ-018 After rst deasserts, the first rising edge SHALL be able to accept a req.

Structure
REQ-019 Package lsu_pkg SHALL hold:
- size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
- FSM state encodings;
- the lane-width constants.
REQ-020 SHALL place load lane selection and sign/zero extension in one combinational sub-module, lsu_load_align, instantiated once.
- Store merge stays inline.

Verification
REQ-021 Word 0 = 0x8899AABB; load byte at addr 0x1, signed_ld=1 -> rdata=0xFFFFFFAA, done at E1, err=0.
REQ-022 Same word; load halfword at addr 0x2, signed_ld=0 -> rdata=0x00008899.
REQ-023 Store byte 0x5C at addr 0x3 -> mem_write high exactly in cycle E1-E2, word 0 = 0x5C99AABB, done at E2.
REQ-024 Store word 0x12345678 at addr 0x10 -> word 4 = 0x12345678 at E1, done at E1; a req held high during busy is ignored.
REQ-025 Load word at addr 0x6, then load word at addr 0x100 (DATA_MEM_SIZE=64) -> each gives done=err=1 at E1, mem_write never high, rdata unchanged.
REQ-026 Store halfword; assert rst during MERGE -> mem_write stays 0, memory unchanged, all outputs 0 immediately.
